retrodack_boot_copier: RTL and testbench

Bus initiator that copies a block of 32-bit words from a read-only responder (boot ROM) into a read/write responder (RAM), sitting between the boot ROM and system RAM during bring-up. It drives the single-request/ready read protocol that the ROM answers, buffers words in a small FIFO so reads and writes overlap, and accumulates a 32-bit additive checksum of the copied data for firmware validation.

---
 rtl/retrodack_boot_copier.sv | 151 +++++++++++++++
 tb/tb_retrodack_boot_copier.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retrodack_boot_copier.sv
// retrodack_boot_copier: copies a block of words from boot ROM to RAM through a small FIFO,
// overlapping reads with writes and accumulating an additive checksum of the data written.
//
// state | meaning
// IDLE  | waiting for i_start; outputs hold the last result
// RUN   | read and write sides operating concurrently
// DONE  | one-cycle completion pulse, then back to IDLE
module retrodack_boot_copier #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_source,
  input  logic [31:0] i_target,
  input  logic [31:0] i_count,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_checksum,
  output logic        o_rom_request,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_rdata,
  input  logic        i_rom_ready,
  output logic        o_ram_request,
  output logic        o_ram_rw,
  output logic [31:0] o_ram_address,
  output logic [31:0] o_ram_wdata,
  input  logic        i_ram_ready
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FILL_MAX = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [31:0]      src_base;
  logic [31:0]      tgt_base;
  logic [31:0]      total;
  logic [31:0]      rd_idx;
  logic [31:0]      wr_idx;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] push_ptr;
  logic [PTR_W-1:0] pop_ptr;
  logic [PTR_W:0]   fill;

  logic rom_accept;
  logic rom_issue;
  logic ram_accept;
  logic ram_pop;
  logic last_write;

  // A request register that is low means nothing is outstanding on that side, and
  // issuing only from that state guarantees one idle cycle between transactions.
  // A ready seen while the request is low (trailing responder) is simply ignored.
  assign rom_accept = o_rom_request & i_rom_ready;
  assign ram_accept = o_ram_request & i_ram_ready;
  assign rom_issue  = (state == S_RUN) & ~o_rom_request & (rd_idx < total) & (fill < FILL_MAX);
  assign ram_pop    = (state == S_RUN) & ~o_ram_request & (fill != '0);
  assign last_write = ram_accept & ((wr_idx + 32'd1) == total);

  assign o_busy   = (state == S_RUN);
  assign o_done   = (state == S_DONE);
  assign o_ram_rw = 1'b1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      src_base      <= '0;
      tgt_base      <= '0;
      total         <= '0;
      rd_idx        <= '0;
      wr_idx        <= '0;
      push_ptr      <= '0;
      pop_ptr       <= '0;
      fill          <= '0;
      o_checksum    <= '0;
      o_rom_request <= 1'b0;
      o_rom_address <= '0;
      o_ram_request <= 1'b0;
      o_ram_address <= '0;
      o_ram_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            src_base   <= i_source & WORD_MASK;
            tgt_base   <= i_target & WORD_MASK;
            total      <= i_count;
            rd_idx     <= '0;
            wr_idx     <= '0;
            push_ptr   <= '0;
            pop_ptr    <= '0;
            fill       <= '0;
            o_checksum <= '0;
            if (i_count == 32'd0) begin
              state <= S_DONE;
            end else begin
              // first read goes out straight from the start edge
              state         <= S_RUN;
              o_rom_request <= 1'b1;
              o_rom_address <= i_source & WORD_MASK;
            end
          end
        end
        S_RUN: begin
          if (rom_accept) begin
            o_rom_request <= 1'b0;
            rd_idx        <= rd_idx + 32'd1;
            push_ptr      <= push_ptr + 1'b1;
          end else if (rom_issue) begin
            o_rom_request <= 1'b1;
            o_rom_address <= src_base + (rd_idx << 2);
          end

          if (ram_accept) begin
            o_ram_request <= 1'b0;
            wr_idx        <= wr_idx + 32'd1;
            o_checksum    <= o_checksum + o_ram_wdata;
          end else if (ram_pop) begin
            o_ram_request <= 1'b1;
            o_ram_address <= tgt_base + (wr_idx << 2);
            o_ram_wdata   <= fifo_mem[pop_ptr];
            pop_ptr       <= pop_ptr + 1'b1;
          end

          fill <= fill + (PTR_W + 1)'(rom_accept) - (PTR_W + 1)'(ram_pop);

          if (last_write) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (rom_accept) begin
      fifo_mem[push_ptr] <= i_rom_rdata;
    end
  end

endmodule

// File: tb/tb_retrodack_boot_copier.sv
// Self-checking bench for retrodack_boot_copier: ROM/RAM responder models with an
// expected-transaction scoreboard for reads and writes.
module tb_retrodack_boot_copier;
  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic [31:0] i_source;
  logic [31:0] i_target;
  logic [31:0] i_count;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_checksum;
  logic        o_rom_request;
  logic [31:0] o_rom_address;
  logic [31:0] i_rom_rdata;
  logic        i_rom_ready;
  logic        o_ram_request;
  logic        o_ram_rw;
  logic [31:0] o_ram_address;
  logic [31:0] o_ram_wdata;
  logic        i_ram_ready;

  always #5 clk = ~clk;

  retrodack_boot_copier #(.FIFO_DEPTH(4)) dut (
    .i_clock(clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_source(i_source),
    .i_target(i_target),
    .i_count(i_count),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_checksum(o_checksum),
    .o_rom_request(o_rom_request),
    .o_rom_address(o_rom_address),
    .i_rom_rdata(i_rom_rdata),
    .i_rom_ready(i_rom_ready),
    .o_ram_request(o_ram_request),
    .o_ram_rw(o_ram_rw),
    .o_ram_address(o_ram_address),
    .o_ram_wdata(o_ram_wdata),
    .i_ram_ready(i_ram_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  logic [31:0] rom_mem [256];
  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_wr_q [$];

  int ram_lat   = 0;
  bit rom_stale = 1'b0;
  int reads_done = 0;
  int writes_done = 0;
  int wr_issued = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  int rom_rises = 0;
  int ram_rises = 0;
  int max_ahead = 0;

  // ROM responder: ready in the cycle after the request is seen; optional trailing stale ready
  initial begin : rom_resp
    bit acc_pending;
    logic [31:0] ea;
    acc_pending = 1'b0;
    i_rom_ready = 1'b0;
    i_rom_rdata = '0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        i_rom_ready = 1'b0;
        acc_pending = 1'b0;
      end else if (acc_pending) begin
        acc_pending = 1'b0;
        chk("rom_gap", {31'd0, o_rom_request}, 32'd0);
        if (!rom_stale) i_rom_ready = 1'b0;
      end else if (i_rom_ready) begin
        i_rom_ready = 1'b0;
      end else if (o_rom_request) begin
        if (exp_rd_q.size() == 0) begin
          chk("rom_extra_read", 32'd1, 32'd0);
        end else begin
          ea = exp_rd_q.pop_front();
          chk("rom_addr", o_rom_address, ea);
        end
        i_rom_rdata = rom_mem[o_rom_address[9:2]];
        i_rom_ready = 1'b1;
        acc_pending = 1'b1;
        reads_done++;
      end
    end
  end

  // RAM responder: ready after ram_lat cycles of request
  initial begin : ram_resp
    bit acc_pending;
    int wait_cnt;
    logic [63:0] ew;
    acc_pending = 1'b0;
    wait_cnt = 0;
    i_ram_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        i_ram_ready = 1'b0;
        acc_pending = 1'b0;
        wait_cnt = 0;
      end else if (acc_pending) begin
        acc_pending = 1'b0;
        i_ram_ready = 1'b0;
        chk("ram_gap", {31'd0, o_ram_request}, 32'd0);
      end else if (o_ram_request) begin
        if (wait_cnt >= ram_lat) begin
          wait_cnt = 0;
          if (exp_wr_q.size() == 0) begin
            chk("ram_extra_write", 32'd1, 32'd0);
          end else begin
            ew = exp_wr_q.pop_front();
            chk("ram_addr", o_ram_address, ew[63:32]);
            chk("ram_data", o_ram_wdata, ew[31:0]);
          end
          chk("ram_rw", {31'd0, o_ram_rw}, 32'd1);
          i_ram_ready = 1'b1;
          acc_pending = 1'b1;
          writes_done++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin : monitor
    bit rom_last;
    bit ram_last;
    rom_last = 1'b0;
    ram_last = 1'b0;
    forever begin
      @(negedge clk);
      if (i_reset_n) begin
        if (o_done) done_cnt++;
        if (o_busy) busy_cycles++;
        if (o_rom_request && !rom_last) rom_rises++;
        if (o_ram_request && !ram_last) begin
          ram_rises++;
          wr_issued++;
        end
        if (reads_done - wr_issued > max_ahead) max_ahead = reads_done - wr_issued;
      end
      rom_last = o_rom_request;
      ram_last = o_ram_request;
    end
  end

  task automatic load_expect(input logic [31:0] src, input logic [31:0] tgt, input logic [31:0] cnt,
                             output logic [31:0] sum);
    logic [31:0] ra;
    logic [31:0] wa;
    sum = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      ra = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      wa = (tgt & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_rd_q.push_back(ra);
      exp_wr_q.push_back({wa, rom_mem[ra[9:2]]});
      sum = sum + rom_mem[ra[9:2]];
    end
  endtask

  task automatic pulse_start(input logic [31:0] src, input logic [31:0] tgt, input logic [31:0] cnt);
    @(negedge clk);
    i_source = src;
    i_target = tgt;
    i_count  = cnt;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] tgt, input logic [31:0] cnt,
                          input int rlat, input bit stale, input bit poke_start);
    logic [31:0] sum;
    int d0;
    int n;
    ram_lat     = rlat;
    rom_stale   = stale;
    reads_done  = 0;
    writes_done = 0;
    wr_issued   = 0;
    max_ahead   = 0;
    load_expect(src, tgt, cnt, sum);
    d0 = done_cnt;
    pulse_start(src, tgt, cnt);
    chk("rom_req_after_start", {31'd0, o_rom_request}, {31'd0, cnt != 0});
    chk("done_after_start", {31'd0, o_done}, {31'd0, cnt == 0});
    if (poke_start) begin
      repeat (3) @(negedge clk);
      i_source = 32'h0000_0040;
      i_target = 32'h0000_3000;
      i_count  = 32'd1;
      i_start  = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, n < 3000}, 32'd1);
    repeat (4) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("checksum", o_checksum, sum);
    chk("reads", 32'(reads_done), cnt);
    chk("writes", 32'(writes_done), cnt);
    chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int d0;
    int b0;
    int rr0;
    int wr0;
    int n;
    logic [31:0] sum;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h1111_1111;
    rom_mem[1] = 32'h2222_2222;
    rom_mem[2] = 32'h3333_3333;

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_source  = '0;
    i_target  = '0;
    i_count   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_checksum", o_checksum, 32'd0);
    chk("rst_rom_req", {31'd0, o_rom_request}, 32'd0);
    chk("rst_rom_addr", o_rom_address, 32'd0);
    chk("rst_ram_req", {31'd0, o_ram_request}, 32'd0);
    chk("rst_ram_addr", o_ram_address, 32'd0);
    chk("rst_ram_wdata", o_ram_wdata, 32'd0);
    chk("rst_ram_rw", {31'd0, o_ram_rw}, 32'd1);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic three-word copy
    run_copy(32'h0, 32'h1000, 32'd3, 0, 1'b0, 1'b0);
    chk("basic_checksum", o_checksum, 32'h6666_6666);

    // RAM stalls: read-ahead bounded by FIFO depth
    run_copy(32'h100, 32'h2000, 32'd8, 10, 1'b0, 1'b0);
    chk("max_ahead_le_depth", {31'd0, max_ahead <= 4}, 32'd1);

    // zero-length copy
    b0 = busy_cycles;
    rr0 = rom_rises;
    wr0 = ram_rises;
    run_copy(32'h200, 32'h2400, 32'd0, 0, 1'b0, 1'b0);
    chk("zero_busy", 32'(busy_cycles - b0), 32'd0);
    chk("zero_rom_reqs", 32'(rom_rises - rr0), 32'd0);
    chk("zero_ram_reqs", 32'(ram_rises - wr0), 32'd0);
    chk("zero_checksum", o_checksum, 32'd0);

    // unaligned addresses and target wrap past the top of memory
    run_copy(32'h3, 32'hFFFF_FFFE, 32'd2, 1, 1'b0, 1'b0);

    // trailing ROM ready after each read, plus start pulsed mid-run
    run_copy(32'h300, 32'h5000, 32'd6, 2, 1'b1, 1'b1);

    // reset during the fifth write of sixteen
    ram_lat = 3;
    rom_stale = 1'b0;
    reads_done = 0;
    writes_done = 0;
    wr_issued = 0;
    load_expect(32'h80, 32'h6000, 32'd16, sum);
    d0 = done_cnt;
    pulse_start(32'h80, 32'h6000, 32'd16);
    n = 0;
    while (wr_issued < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach_5th", {31'd0, n < 2000}, 32'd1);
    chk("ram_req_before_rst", {31'd0, o_ram_request}, 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst_mid_rom_req", {31'd0, o_rom_request}, 32'd0);
    chk("rst_mid_ram_req", {31'd0, o_ram_request}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_checksum", o_checksum, 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_done_after", 32'(done_cnt - d0), 32'd0);
    run_copy(32'h80, 32'h6000, 32'd16, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
